// File: rtl/cubic_tap_feeder.sv
// cubic_tap_feeder: 4-tap window producer for 2x cubic upscaling.
// Option: define CUBIC_FEED_ZERO_EDGE_EN for zero-valued edge taps.
module cubic_tap_feeder #(
  parameter int bit_depth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [bit_depth-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bit_depth-1:0] a0,
  output logic [bit_depth-1:0] a1,
  output logic [bit_depth-1:0] a2,
  output logic [bit_depth-1:0] a3,
  output logic                 out_phase,
  output logic                 out_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t               r_state;
  state_t               w_nxt;

  logic [bit_depth-1:0] r_w0;
  logic [bit_depth-1:0] r_w1;
  logic [bit_depth-1:0] r_w2;
  logic [bit_depth-1:0] r_w3;
  logic [1:0]           r_l;
  logic [1:0]           r_dcnt;
  logic                 r_ov;
  logic                 r_ph;
  logic                 r_last;
  logic                 r_final;

  logic                 w_adv;
  logic                 w_ready;
  logic                 w_acc;
  logic                 w_ph0_hs;
  logic [1:0]           w_lpost;
  logic [bit_depth-1:0] w_eload;
  logic [bit_depth-1:0] w_edrain;

  logic                 w_load;
  logic                 w_shift;
  logic [bit_depth-1:0] w_new;
  logic                 w_present;
  logic                 w_final;
  logic                 w_clear;
  logic                 w_dinc;
  logic                 w_dclr;

`ifdef CUBIC_FEED_ZERO_EDGE_EN
  assign w_eload  = '0;
  assign w_edrain = '0;
`else
  assign w_eload  = in_data;
  assign w_edrain = r_w3;
`endif

  // The output slot is free once nothing undelivered remains.
  assign w_adv    = !r_ov || (out_ready && r_ph);
  assign w_ph0_hs = r_ov && !r_ph && out_ready;
  assign w_lpost  = (r_l == 2'd2) ? 2'd2 : r_l + 2'd1;

  assign in_ready  = w_ready;
  assign w_acc     = in_valid && w_ready;
  assign out_valid = r_ov;
  assign out_phase = r_ph;
  assign out_last  = r_last;
  assign a0        = r_w0;
  assign a1        = r_w1;
  assign a2        = r_w2;
  assign a3        = r_w3;

  // Input acceptance depends only on state and output slot.
  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_FILL:  w_ready = 1'b1;
      S_RUN:   w_ready = w_adv;
      S_DRAIN: w_ready = 1'b0;
      default: w_ready = 1'b0;
    endcase
  end

  // Next state and datapath controls.
  always_comb begin
    w_nxt     = r_state;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_new     = in_data;
    w_present = 1'b0;
    w_final   = 1'b0;
    w_clear   = 1'b0;
    w_dinc    = 1'b0;
    w_dclr    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_load = 1'b1;
          w_dclr = 1'b1;
          w_nxt  = in_last ? S_DRAIN : S_FILL;
        end
      end
      S_FILL: begin
        if (w_acc) begin
          w_shift   = 1'b1;
          w_present = (w_lpost == 2'd2);
          if (in_last)
            w_nxt = S_DRAIN;
          else if (w_lpost == 2'd2)
            w_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_acc) begin
          w_shift   = 1'b1;
          w_present = 1'b1;
          if (in_last)
            w_nxt = S_DRAIN;
        end else if (w_adv) begin
          w_clear = 1'b1;
        end
      end
      S_DRAIN: begin
        w_new = w_edrain;
        if (w_adv) begin
          if (r_dcnt != 2'd2) begin
            w_shift = 1'b1;
            w_dinc  = 1'b1;
            if (w_lpost == 2'd2) begin
              w_present = 1'b1;
              w_final   = (r_dcnt == 2'd1);
            end else begin
              w_clear = 1'b1;
            end
          end else begin
            w_clear = 1'b1;
            w_nxt   = S_IDLE;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end

  // Tap window, fill level and drain shift count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w0   <= '0;
      r_w1   <= '0;
      r_w2   <= '0;
      r_w3   <= '0;
      r_l    <= 2'd0;
      r_dcnt <= 2'd0;
    end else begin
      if (w_load) begin
        r_w0 <= w_eload;
        r_w1 <= w_eload;
        r_w2 <= w_eload;
        r_w3 <= in_data;
        r_l  <= 2'd0;
      end else if (w_shift) begin
        r_w0 <= r_w1;
        r_w1 <= r_w2;
        r_w2 <= r_w3;
        r_w3 <= w_new;
        r_l  <= w_lpost;
      end
      if (w_dclr)
        r_dcnt <= 2'd0;
      else if (w_dinc)
        r_dcnt <= r_dcnt + 2'd1;
    end
  end

  // Beat sequencing: phase 0 then phase 1 per window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ov    <= 1'b0;
      r_ph    <= 1'b0;
      r_last  <= 1'b0;
      r_final <= 1'b0;
    end else if (w_present) begin
      r_ov    <= 1'b1;
      r_ph    <= 1'b0;
      r_last  <= 1'b0;
      r_final <= w_final;
    end else if (w_clear) begin
      r_ov    <= 1'b0;
      r_ph    <= 1'b0;
      r_last  <= 1'b0;
      r_final <= 1'b0;
    end else if (w_ph0_hs) begin
      r_ph    <= 1'b1;
      r_last  <= r_final;
    end
  end

endmodule

// File: tb/tb_cubic_tap_feeder.sv
// tb_cubic_tap_feeder: directed vectors for cubic_tap_feeder.
// Expected edge taps follow CUBIC_FEED_ZERO_EDGE_EN when defined.
module tb_cubic_tap_feeder;

`ifdef CUBIC_FEED_ZERO_EDGE_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a0, a1, a2, a3;
  logic       out_phase;
  logic       out_last;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] pin;
    logic       lst;
    logic [7:0] e0, e1, e2, e3;
  } vec_t;

  typedef struct {
    logic [7:0] t0, t1, t2, t3;
    logic       ph;
    logic       lst;
  } beat_t;

  vec_t       vecs[$];
  beat_t      exp_q[$];
  logic [7:0] pix[$];

  always #5 clk = ~clk;

  cubic_tap_feeder #(.bit_depth(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .a0       (a0),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .out_phase(out_phase),
    .out_last (out_last)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic addv(input logic [7:0] p, input logic l,
                      input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3);
    vec_t v;
    v.pin = p; v.lst = l;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] tap(input int j);
    int n = pix.size();
    if (j < 0) return ZERO ? 8'd0 : pix[0];
    if (j >= n) return ZERO ? 8'd0 : pix[n-1];
    return pix[j];
  endfunction

  // Reference windows taken directly from a padded view of the line.
  task automatic model_beats();
    exp_q.delete();
    for (int i = 0; i < pix.size(); i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        beat_t b;
        b.t0 = tap(i - 1);
        b.t1 = tap(i);
        b.t2 = tap(i + 1);
        b.t3 = tap(i + 2);
        b.ph = (ph == 1);
        b.lst = (ph == 1) && (i == pix.size() - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_line(input string tag, input int stall_at,
                          input int stall_len, input bit cont_chk);
    int pi = 0;
    int bi = 0;
    int cyc = 0;
    int first_c = -1;
    int last_c = -1;
    int stall_left = stall_len;
    bit last_acc = 1'b0;
    logic [63:0] snap = '0;
    logic [63:0] cur;
    beat_t b;
    while (bi < exp_q.size() && cyc < 400) begin
      @(negedge clk);
      in_valid = (pi < pix.size());
      in_data = in_valid ? pix[pi] : 8'd0;
      in_last = in_valid && (pi == pix.size() - 1);
      out_ready = !(bi == stall_at && stall_left > 0 && out_valid);
      #1;
      cur = {26'd0, a0, a1, a2, a3, out_phase, out_valid, out_last};
      if (!out_ready) begin
        if (stall_left == stall_len)
          snap = cur;
        else
          chk({tag, " stall_hold"}, cur, snap);
        chk({tag, " stall_in_ready"}, {63'd0, in_ready}, 64'd0);
        stall_left--;
      end
      if (last_acc)
        chk({tag, " drain_in_ready"}, {63'd0, in_ready}, 64'd0);
      else if (out_valid && out_ready)
        chk({tag, " run_in_ready"}, {63'd0, in_ready},
            {63'd0, out_phase});
      if (out_valid && out_ready) begin
        b = exp_q[bi];
        chk($sformatf("%s beat%0d", tag, bi),
            {30'd0, a0, a1, a2, a3, out_phase, out_last},
            {30'd0, b.t0, b.t1, b.t2, b.t3, b.ph, b.lst});
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        bi++;
      end
      if (in_valid && in_ready) begin
        if (in_last) last_acc = 1'b1;
        pi++;
      end
      cyc++;
    end
    chk({tag, " beats_seen"}, bi, exp_q.size());
    chk({tag, " pixels_taken"}, pi, pix.size());
    if (cont_chk)
      chk({tag, " beat_span"}, last_c - first_c, exp_q.size() - 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    chk({tag, " idle"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    in_last = 1'b0;
    out_ready = 1'b1;

    // Vector table: pixel, last flag, expected window for that pixel.
    if (!ZERO) begin
      addv(8'd10, 1'b0, 8'd10, 8'd10, 8'd20, 8'd30);
      addv(8'd20, 1'b0, 8'd10, 8'd20, 8'd30, 8'd40);
      addv(8'd30, 1'b0, 8'd20, 8'd30, 8'd40, 8'd40);
      addv(8'd40, 1'b1, 8'd30, 8'd40, 8'd40, 8'd40);
      addv(8'd77, 1'b1, 8'd77, 8'd77, 8'd77, 8'd77);
      addv(8'd5,  1'b0, 8'd5,  8'd5,  8'd9,  8'd9);
      addv(8'd9,  1'b1, 8'd5,  8'd9,  8'd9,  8'd9);
      addv(8'd1,  1'b0, 8'd1,  8'd1,  8'd2,  8'd3);
      addv(8'd2,  1'b0, 8'd1,  8'd2,  8'd3,  8'd3);
      addv(8'd3,  1'b1, 8'd2,  8'd3,  8'd3,  8'd3);
    end else begin
      addv(8'd10, 1'b0, 8'd0,  8'd10, 8'd20, 8'd30);
      addv(8'd20, 1'b0, 8'd10, 8'd20, 8'd30, 8'd40);
      addv(8'd30, 1'b0, 8'd20, 8'd30, 8'd40, 8'd0);
      addv(8'd40, 1'b1, 8'd30, 8'd40, 8'd0,  8'd0);
      addv(8'd77, 1'b1, 8'd0,  8'd77, 8'd0,  8'd0);
      addv(8'd5,  1'b0, 8'd0,  8'd5,  8'd9,  8'd0);
      addv(8'd9,  1'b1, 8'd5,  8'd9,  8'd0,  8'd0);
      addv(8'd1,  1'b0, 8'd0,  8'd1,  8'd2,  8'd3);
      addv(8'd2,  1'b0, 8'd1,  8'd2,  8'd3,  8'd0);
      addv(8'd3,  1'b1, 8'd2,  8'd3,  8'd0,  8'd0);
    end

    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {27'd0, out_valid, out_phase, out_last, a0, a1, a2, a3},
        64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      beat_t b;
      v = vecs[k];
      pix.push_back(v.pin);
      for (int ph = 0; ph < 2; ph++) begin
        b.t0 = v.e0; b.t1 = v.e1; b.t2 = v.e2; b.t3 = v.e3;
        b.ph = (ph == 1);
        b.lst = (ph == 1) && v.lst;
        exp_q.push_back(b);
      end
      if (v.lst) begin
        run_line($sformatf("tbl_n%0d", pix.size()), -1, 0, 1'b0);
        pix.delete();
        exp_q.delete();
      end
    end

    // Backpressure: stall on a mid-line phase-1 beat.
    for (int i = 0; i < 8; i++) pix.push_back(8'(i * 11 + 4));
    model_beats();
    run_line("stall", 5, 5, 1'b0);
    pix.delete();

    // Backpressure landing on a phase-0 beat during drain.
    for (int i = 0; i < 5; i++) pix.push_back(8'(200 - i * 13));
    model_beats();
    run_line("stall_drain", 8, 5, 1'b0);
    pix.delete();

    // Continuous 16-pixel line at full rate.
    for (int i = 0; i < 16; i++) pix.push_back(8'(i * 7 + 3));
    model_beats();
    run_line("cont16", -1, 0, 1'b1);
    pix.delete();

    // Reset partway through a line, then a fresh line.
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'd50;
    in_last = 1'b0;
    @(negedge clk);
    in_data = 8'd60;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset_outs",
        {27'd0, out_valid, out_phase, out_last, a0, a1, a2, a3}, 64'd0);
    chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    pix.push_back(8'd1);
    pix.push_back(8'd2);
    pix.push_back(8'd3);
    model_beats();
    run_line("after_reset", -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
